mem_swap_engine: RTL and testbench
==================================

Name: mem_swap_engine

Overview:
- Responder end of the memory-swap protocol: accepts a swap command naming two locations and performs the three-move exchange (A→T, B→A, T→B) on its own register-file memory.
- Reports progress with a busy/done handshake.
- Provides a host write port and a combinational read port, used to load the memory and inspect it between swaps.

Parameters:
DATA_W, 8, width of each memory word and of the temp register
ADDR_W, 3, address width; memory depth is 2**ADDR_W words

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
swap_req  input  1  swap command strobe; sampled only in IDLE
addr_a  input  ADDR_W  first swap location; captured when swap_req is accepted
addr_b  input  ADDR_W  second swap location; captured when swap_req is accepted
wr_en  input  1  host write enable; honoured only in IDLE
wr_addr  input  ADDR_W  host write address
wr_data  input  DATA_W  host write data
rd_addr  input  ADDR_W  host read address
rd_data  output  DATA_W  combinational mem[rd_addr]
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, high only in DONE

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, busy=0, done=0, temp=0.
  - Latched addresses = 0; every memory word = 0.
  - Takes effect immediately, including mid-swap; a partial swap is abandoned.
- States: IDLE → LOAD → MOVE_BA → MOVE_TB → DONE → IDLE.
  - busy = (state != IDLE); done = (state == DONE); both decoded from the state register (registered outputs).
- IDLE:
  - swap_req=1 at an edge: latch a_q=addr_a, b_q=addr_b; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD: on the edge leaving LOAD, temp <= mem[a_q].
- MOVE_BA: on the edge leaving MOVE_BA, mem[a_q] <= mem[b_q].
- MOVE_TB: on the edge leaving MOVE_TB, mem[b_q] <= temp.
- DONE: swapped contents are visible on rd_data; return to IDLE on the next edge unconditionally.
- Latency:
  - swap_req sampled at edge 0 → busy high in cycles 1..4 → done high in cycle 4 only → IDLE (busy=0) from cycle 5.
  - Back-to-back swaps: minimum 5 cycles between accepted requests.
- swap_req outside IDLE (including DONE): ignored, not queued. addr_a/addr_b changes while busy have no effect.
- Host writes:
  - wr_en in IDLE writes mem[wr_addr] <= wr_data at the edge.
  - wr_en while busy is dropped silently.
- Simultaneous wr_en and accepted swap_req in IDLE: the write commits at edge 0. LOAD reads at edge 1, so the swap operates on the post-write contents.
- addr_a == addr_b: full sequence still runs (same 4-cycle busy, done pulse); memory is left unchanged.
- rd_data:
  - Pure combinational read, valid in every state.
  - During MOVE_TB, mem[a_q] already holds old B while mem[b_q] still holds old B; the intermediate state is visible and legal.
- temp retains its last value after a swap; it is not cleared in IDLE.
- Arithmetic: none; all transfers are full DATA_W copies with no width conversion.

Test Plan:
1. Reset then read all 8 addresses → rd_data=0 everywhere; busy=0, done=0.
2. Load mem[2]=0xA5 and mem[5]=0x3C. Pulse swap_req with a=2, b=5 at edge 0. Required: busy=1 in cycles 1-4; done=1 in cycle 4 only; mem[2]=0x3C and mem[5]=0xA5; all other words unchanged.
3. Swap with a=b=4 where mem[4]=0x77 → done in cycle 4; mem[4]=0x77; no other word changes.
4. During a swap of 1↔6, assert swap_req with a=0, b=7 and wr_en to address 3 with data 0xFF in cycles 2-3. Required: only the 1↔6 swap occurs; mem[0], mem[7] and mem[3] unchanged; exactly one done pulse.
5. Same edge in IDLE: wr_en to addr 1 with data 0x11, plus swap_req with a=1, b=0 (mem[0]=0x22). Required: after done, mem[1]=0x22 and mem[0]=0x11.
6. Start a 2↔5 swap and drop reset_n in cycle 3. Required: immediately busy=0, done=0, all memory=0. After release, swap_req is accepted on the first edge.

Source files
------------

// File: rtl/mem_swap_engine_if.sv
// Host-side bundle for the memory swap engine: swap command,
// host write/read ports and the busy/done status.
interface mem_swap_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              swap_req;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;

    modport master (
        output swap_req, addr_a, addr_b,
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done
    );

    modport slave (
        input  swap_req, addr_a, addr_b,
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done
    );
endinterface

// File: rtl/mem_swap_engine.sv
// Swap responder: exchanges two words of a local register file
// through a temp register in three moves, with busy/done status.
module mem_swap_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_swap_engine_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        MOVE_BA = 3'd2,
        MOVE_TB = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_a_q;
    logic [ADDR_W-1:0] r_b_q;
    logic [DATA_W-1:0] r_temp;
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign bus.rd_data = r_mem[bus.rd_addr];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // busy/done are updated alongside the state so they stay registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_temp  <= '0;
            r_mem   <= '{default: '0};
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.wr_en) begin
                        r_mem[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.swap_req) begin
                        r_a_q   <= bus.addr_a;
                        r_b_q   <= bus.addr_b;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_temp  <= r_mem[r_a_q];
                    r_state <= MOVE_BA;
                end
                MOVE_BA: begin
                    r_mem[r_a_q] <= r_mem[r_b_q];
                    r_state      <= MOVE_TB;
                end
                MOVE_TB: begin
                    r_mem[r_b_q] <= r_temp;
                    r_state      <= DONE;
                    r_done       <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_swap_engine.sv
// Directed bench for mem_swap_engine: host write/read table,
// then hand-written swap sequences with latency and reset checks.
module tb_mem_swap_engine;
    logic clk;
    logic reset_n;

    mem_swap_engine_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    mem_swap_engine #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [7:0] exp;
    } vec_t;

    int n_tests;
    int n_fail;
    logic [7:0] model [8];
    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr = 3'(i);
            #1;
            chk($sformatf("%s mem[%0d]", tag, i), 32'(bus.rd_data),
                32'(model[i]));
        end
    endtask

    // full swap with latency checks; optional same-edge host write
    task automatic do_swap(input string tag, input logic [2:0] a,
                           input logic [2:0] b, input logic wen,
                           input logic [2:0] wa, input logic [7:0] wd);
        logic [7:0] t;
        bus.swap_req = 1'b1;
        bus.addr_a   = a;
        bus.addr_b   = b;
        bus.wr_en    = wen;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        tick();
        bus.swap_req = 1'b0;
        bus.wr_en    = 1'b0;
        if (wen) model[wa] = wd;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("%s busy c%0d", tag, c), 32'(bus.busy),
                32'(c <= 4));
            chk($sformatf("%s done c%0d", tag, c), 32'(bus.done),
                32'(c == 4));
            if (c == 3 && a != b) begin
                bus.rd_addr = a;
                #1;
                chk($sformatf("%s mid a", tag), 32'(bus.rd_data),
                    32'(model[b]));
                bus.rd_addr = b;
                #1;
                chk($sformatf("%s mid b", tag), 32'(bus.rd_data),
                    32'(model[b]));
            end
            if (c < 5) tick();
        end
        t        = model[a];
        model[a] = model[b];
        model[b] = t;
        check_mem(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{1'b1, 3'd2, 8'hA5, 3'd2, 8'hA5};
        vecs[1] = '{1'b1, 3'd5, 8'h3C, 3'd5, 8'h3C};
        vecs[2] = '{1'b1, 3'd4, 8'h77, 3'd2, 8'hA5};
        vecs[3] = '{1'b1, 3'd1, 8'h5A, 3'd4, 8'h77};
        vecs[4] = '{1'b1, 3'd6, 8'hC3, 3'd1, 8'h5A};
        vecs[5] = '{1'b1, 3'd0, 8'h22, 3'd6, 8'hC3};
        vecs[6] = '{1'b1, 3'd3, 8'h0F, 3'd0, 8'h22};
        vecs[7] = '{1'b1, 3'd7, 8'hE7, 3'd3, 8'h0F};
        vecs[8] = '{1'b0, 3'd0, 8'h99, 3'd7, 8'hE7};
        vecs[9] = '{1'b0, 3'd0, 8'h99, 3'd0, 8'h22};

        reset_n      = 1'b0;
        bus.swap_req = 1'b0;
        bus.addr_a   = '0;
        bus.addr_b   = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // reset state
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        check_mem("reset");

        // host write/read table
        for (int v = 0; v < 10; v++) begin
            bus.wr_en   = vecs[v].wr;
            bus.wr_addr = vecs[v].wa;
            bus.wr_data = vecs[v].wd;
            bus.rd_addr = vecs[v].ra;
            tick();
            bus.wr_en = 1'b0;
            if (vecs[v].wr) model[vecs[v].wa] = vecs[v].wd;
            chk($sformatf("vec%0d rd", v), 32'(bus.rd_data),
                32'(vecs[v].exp));
        end

        do_swap("swap25", 3'd2, 3'd5, 1'b0, 3'd0, 8'h00);
        chk("swap25 m2", 32'(model[2]), 32'h3C);
        do_swap("swap44", 3'd4, 3'd4, 1'b0, 3'd0, 8'h00);

        // requests and writes while busy are dropped
        bus.swap_req = 1'b1;
        bus.addr_a   = 3'd1;
        bus.addr_b   = 3'd6;
        tick();
        bus.swap_req = 1'b0;
        dones = 0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.done) dones++;
            if (c == 2) begin
                bus.swap_req = 1'b1;
                bus.addr_a   = 3'd0;
                bus.addr_b   = 3'd7;
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 3'd3;
                bus.wr_data  = 8'hFF;
            end
            if (c == 4) begin
                bus.swap_req = 1'b0;
                bus.wr_en    = 1'b0;
            end
            tick();
        end
        chk("busyreq dones", 32'(dones), 32'd1);
        chk("busyreq idle", 32'(bus.busy), 32'd0);
        model[1] = 8'hC3;
        model[6] = 8'h5A;
        check_mem("busyreq");

        // same-edge write and swap: swap sees the written value
        do_swap("wrswap", 3'd1, 3'd0, 1'b1, 3'd1, 8'h11);
        bus.rd_addr = 3'd1;
        #1;
        chk("wrswap m1", 32'(bus.rd_data), 32'h22);
        bus.rd_addr = 3'd0;
        #1;
        chk("wrswap m0", 32'(bus.rd_data), 32'h11);

        // reset mid-swap
        bus.swap_req = 1'b1;
        bus.addr_a   = 3'd2;
        bus.addr_b   = 3'd5;
        tick();
        bus.swap_req = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        check_mem("rst");
        #1;
        reset_n      = 1'b1;
        bus.swap_req = 1'b1;
        bus.addr_a   = 3'd3;
        bus.addr_b   = 3'd4;
        tick();
        bus.swap_req = 1'b0;
        chk("post-rst accept", 32'(bus.busy), 32'd1);
        tick();
        tick();
        tick();
        chk("post-rst done", 32'(bus.done), 32'd1);
        tick();
        chk("post-rst idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
